// File: rtl/hi_lo_muldiv_unit_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package hilo_pkg;

  // Operation codes presented by the EX stage; encoding 7 is unused and behaves as NOP
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } hilo_op_t;

  // Control states of the iterative sequencer
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } hilo_state_t;

  // LO result for a divide by zero; sliced down to the operand width (up to 64 bits)
  localparam logic [63:0] HILO_DIV0_LO = '1;

endpackage

// File: rtl/hi_lo_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the HI/LO unit.
interface hi_lo_muldiv_unit_if import hilo_pkg::*; #(
  parameter int WIDTH = 32
) ();

  logic             op_valid;
  hilo_op_t         op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             rd_hi;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  // Pipeline side drives requests and the read select
  modport master (
    output op_valid, op, src_a, src_b, rd_hi,
    input  out, busy, done
  );

  // The HI/LO unit consumes requests and returns read data and status
  modport slave (
    input  op_valid, op, src_a, src_b, rd_hi,
    output out, busy, done
  );

endinterface

// File: rtl/hi_lo_muldiv_unit_iter_core.sv
// Shared shift/accumulate datapath: shift-add multiply or restoring divide,
// one bit per step, with its own iteration counter.
module hilo_iter_core #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_divMode,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [CNT_W-1:0] o_count
);

  // Upper half carries one spare bit so the multiply carry and the
  // divide trial remainder share a single register
  logic [WIDTH:0]   r_accHi;
  logic [WIDTH-1:0] r_accLo;
  logic [WIDTH-1:0] r_operand;
  logic [CNT_W-1:0] r_count;
  logic             r_divMode;

  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_divShift;
  logic [WIDTH:0]   w_divDiff;
  logic             w_divGe;
  logic [WIDTH:0]   w_nextHi;
  logic [WIDTH-1:0] w_nextLo;

  assign w_mulSum   = r_accHi + (r_accLo[0] ? {1'b0, r_operand} : '0);
  assign w_divShift = {r_accHi[WIDTH-1:0], r_accLo[WIDTH-1]};
  assign w_divDiff  = w_divShift - {1'b0, r_operand};
  assign w_divGe    = (w_divShift >= {1'b0, r_operand});

  // Next accumulator value for one multiply or one divide step
  always_comb begin
    w_nextHi = r_accHi;
    w_nextLo = r_accLo;
    if (r_divMode) begin
      if (w_divGe) begin
        w_nextHi = w_divDiff;
        w_nextLo = {r_accLo[WIDTH-2:0], 1'b1};
      end else begin
        w_nextHi = w_divShift;
        w_nextLo = {r_accLo[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_nextHi = {1'b0, w_mulSum[WIDTH:1]};
      w_nextLo = {w_mulSum[0], r_accLo[WIDTH-1:1]};
    end
  end

  // Load operands on start, otherwise advance one bit per step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_accHi   <= '0;
      r_accLo   <= '0;
      r_operand <= '0;
      r_count   <= '0;
      r_divMode <= 1'b0;
    end else if (i_start) begin
      r_accHi   <= '0;
      r_divMode <= i_divMode;
      r_count   <= CNT_W'(WIDTH);
      if (i_divMode) begin
        r_accLo   <= i_a;
        r_operand <= i_b;
      end else begin
        r_accLo   <= i_b;
        r_operand <= i_a;
      end
    end else if (i_step) begin
      r_accHi <= w_nextHi;
      r_accLo <= w_nextLo;
      r_count <= r_count - 1'b1;
    end
  end

  assign o_hi    = r_accHi[WIDTH-1:0];
  assign o_lo    = r_accLo;
  assign o_count = r_count;

endmodule

// File: rtl/hi_lo_muldiv_unit.sv
// HI/LO architectural registers with iterative MULT/MULTU/DIV/DIVU,
// MTHI/MTLO writes and a combinational MFHI/MFLO read port.
module hi_lo_muldiv_unit import hilo_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  hi_lo_muldiv_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  hilo_state_t      r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_isDiv;
  logic             r_negRes;
  logic             r_negRem;
  logic             r_div0;
  logic [WIDTH-1:0] r_rawA;

  logic               w_isMul;
  logic               w_isDiv;
  logic               w_isSigned;
  logic               w_accept;
  logic               w_step;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [WIDTH-1:0]   w_coreHi;
  logic [WIDTH-1:0]   w_coreLo;
  logic [CNT_W-1:0]   w_count;
  logic [2*WIDTH-1:0] w_product;
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0]   w_quotFix;
  logic [WIDTH-1:0]   w_remFix;

  assign w_isMul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign w_isDiv    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign w_isSigned = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign w_accept   = (r_state == ST_IDLE) && bus.op_valid && (w_isMul || w_isDiv);
  assign w_step     = (r_state == ST_MUL) || (r_state == ST_DIV);

  // The core only ever sees magnitudes; signs are restored in FIN
  assign w_absA = (w_isSigned && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign w_absB = (w_isSigned && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

  hilo_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_accept),
    .i_divMode (w_isDiv),
    .i_step    (w_step),
    .i_a       (w_absA),
    .i_b       (w_absB),
    .o_hi      (w_coreHi),
    .o_lo      (w_coreLo),
    .o_count   (w_count)
  );

  assign w_product = {w_coreHi, w_coreLo};
  assign w_prodFix = r_negRes ? -w_product : w_product;
  assign w_quotFix = r_negRes ? -w_coreLo  : w_coreLo;
  assign w_remFix  = r_negRem ? -w_coreHi  : w_coreHi;

  // Sequencer: accepts ops in IDLE, runs the core, then writes HI/LO in FIN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_isDiv  <= 1'b0;
      r_negRes <= 1'b0;
      r_negRem <= 1'b0;
      r_div0   <= 1'b0;
      r_rawA   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.op_valid) begin
            case (bus.op)
              OP_MTHI: r_hi <= bus.src_a;
              OP_MTLO: r_lo <= bus.src_a;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_state  <= w_isDiv ? ST_DIV : ST_MUL;
                r_busy   <= 1'b1;
                r_isDiv  <= w_isDiv;
                r_negRes <= w_isSigned && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
                r_negRem <= w_isSigned && bus.src_a[WIDTH-1];
                r_div0   <= w_isDiv && (bus.src_b == '0);
                r_rawA   <= bus.src_a;
              end
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (w_count == CNT_W'(1)) begin
            r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          if (r_isDiv) begin
            if (r_div0) begin
              r_hi <= r_rawA;
              r_lo <= HILO_DIV0_LO[WIDTH-1:0];
            end else begin
              r_hi <= w_remFix;
              r_lo <= w_quotFix;
            end
          end else begin
            r_hi <= w_prodFix[2*WIDTH-1:WIDTH];
            r_lo <= w_prodFix[WIDTH-1:0];
          end
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out  = bus.rd_hi ? r_hi : r_lo;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Directed testbench for hi_lo_muldiv_unit at WIDTH=32.
module tb_hi_lo_muldiv_unit;
  import hilo_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hi_lo_muldiv_unit_if #(.WIDTH(32)) bus ();

  hi_lo_muldiv_unit #(
    .WIDTH (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop if something wedges beyond every bounded wait
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One-cycle request, accepted at the posedge between the two negedges
  task automatic driveOp(input hilo_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.src_a    = a;
    bus.src_b    = b;
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
  endtask

  // Counts busy cycles, stopping at the first idle negedge (bounded)
  task automatic waitIdle(output int busyCycles, output int donePulses);
    busyCycles = 0;
    donePulses = 0;
    while (bus.busy === 1'b1 && busyCycles < 100) begin
      if (bus.done === 1'b1) donePulses++;
      busyCycles++;
      @(negedge clk);
    end
  endtask

  // Reads both halves through the combinational read port
  task automatic readHiLo(output logic [31:0] hi, output logic [31:0] lo);
    bus.rd_hi = 1'b1;
    #1 hi = bus.out;
    bus.rd_hi = 1'b0;
    #1 lo = bus.out;
  endtask

  task automatic test_reset;
    logic [31:0] hi, lo;
    readHiLo(hi, lo);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, expected 0", bus.done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h, expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h, expected 00000000", lo); end
  endtask

  task automatic test_mult;
    int bc, dp;
    logic [31:0] hi, lo;
    driveOp(OP_MULT, 32'd7, 32'hFFFFFFFD);
    waitIdle(bc, dp);
    checks++; if (bc !== 33) begin errors++; $display("[TB] FAIL mult_busy_cycles: got %0d, expected 33", bc); end
    checks++; if (dp !== 0) begin errors++; $display("[TB] FAIL mult_done_while_busy: got %0d, expected 0", dp); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL mult_done_pulse: got %b, expected 1", bus.done); end
    readHiLo(hi, lo);
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h, expected ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("[TB] FAIL mult_lo: got %h, expected ffffffeb", lo); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL mult_done_single: got %b, expected 0", bus.done); end
  endtask

  task automatic test_multu;
    int bc, dp;
    logic [31:0] hi, lo;
    driveOp(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitIdle(bc, dp);
    readHiLo(hi, lo);
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL multu_hi: got %h, expected fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("[TB] FAIL multu_lo: got %h, expected 00000001", lo); end
  endtask

  task automatic test_div;
    int bc, dp;
    logic [31:0] hi, lo;
    driveOp(OP_DIV, 32'hFFFFFFF9, 32'd2);
    waitIdle(bc, dp);
    readHiLo(hi, lo);
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_neg_lo: got %h, expected fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_neg_hi: got %h, expected ffffffff", hi); end
    driveOp(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    waitIdle(bc, dp);
    readHiLo(hi, lo);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("[TB] FAIL div_ovf_lo: got %h, expected 80000000", lo); end
    checks++; if (hi !== 32'h00000000) begin errors++; $display("[TB] FAIL div_ovf_hi: got %h, expected 00000000", hi); end
    driveOp(OP_DIVU, 32'd100, 32'd7);
    waitIdle(bc, dp);
    readHiLo(hi, lo);
    checks++; if (lo !== 32'd14) begin errors++; $display("[TB] FAIL divu_lo: got %h, expected 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("[TB] FAIL divu_hi: got %h, expected 00000002", hi); end
  endtask

  task automatic test_div_by_zero;
    int bc, dp;
    logic [31:0] hi, lo;
    driveOp(OP_DIVU, 32'd100, 32'd0);
    waitIdle(bc, dp);
    checks++; if (bc !== 33) begin errors++; $display("[TB] FAIL divu0_busy_cycles: got %0d, expected 33", bc); end
    readHiLo(hi, lo);
    checks++; if (hi !== 32'h00000064) begin errors++; $display("[TB] FAIL divu0_hi: got %h, expected 00000064", hi); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL divu0_lo: got %h, expected ffffffff", lo); end
    driveOp(OP_DIV, 32'hFFFFFFFB, 32'd0);
    waitIdle(bc, dp);
    readHiLo(hi, lo);
    checks++; if (hi !== 32'hFFFFFFFB) begin errors++; $display("[TB] FAIL div0_hi: got %h, expected fffffffb", hi); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div0_lo: got %h, expected ffffffff", lo); end
  endtask

  task automatic test_mthi_mtlo;
    int bc, dp;
    logic [31:0] hi, lo;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = OP_MTHI; bus.src_a = 32'h12345678; bus.src_b = 32'h0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mthi_busy: got %b, expected 0", bus.busy); end
    bus.op = OP_MTLO; bus.src_a = 32'h9ABCDEF0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mtlo_busy: got %b, expected 0", bus.busy); end
    bus.op = hilo_op_t'(3'd7); bus.src_a = 32'hDEADDEAD;
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op = OP_NOP;
    readHiLo(hi, lo);
    checks++; if (hi !== 32'h12345678) begin errors++; $display("[TB] FAIL mthi_value: got %h, expected 12345678", hi); end
    checks++; if (lo !== 32'h9ABCDEF0) begin errors++; $display("[TB] FAIL mtlo_value: got %h, expected 9abcdef0", lo); end
    driveOp(OP_MULT, 32'd2, 32'd3);
    repeat (3) @(negedge clk);
    readHiLo(hi, lo);
    checks++; if (hi !== 32'h12345678) begin errors++; $display("[TB] FAIL busy_read_hi: got %h, expected 12345678", hi); end
    checks++; if (lo !== 32'h9ABCDEF0) begin errors++; $display("[TB] FAIL busy_read_lo: got %h, expected 9abcdef0", lo); end
    driveOp(OP_MULT, 32'd5, 32'd5);
    driveOp(OP_MTLO, 32'h11111111, 32'd0);
    waitIdle(bc, dp);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL ignored_done: got %b, expected 1", bus.done); end
    readHiLo(hi, lo);
    checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL ignored_hi: got %h, expected 00000000", hi); end
    checks++; if (lo !== 32'd6) begin errors++; $display("[TB] FAIL ignored_lo: got %h, expected 00000006", lo); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL ignored_no_queue: got %b, expected 0", bus.busy); end
  endtask

  task automatic test_back_to_back;
    int bc, dp;
    logic [31:0] hi, lo;
    driveOp(OP_MULTU, 32'h10, 32'h10);
    waitIdle(bc, dp);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done: got %b, expected 1", bus.done); end
    bus.op_valid = 1'b1; bus.op = OP_MTHI; bus.src_a = 32'hA5A5A5A5;
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op = OP_NOP;
    readHiLo(hi, lo);
    checks++; if (hi !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL b2b_mthi_on_done: got %h, expected a5a5a5a5", hi); end
    checks++; if (lo !== 32'h00000100) begin errors++; $display("[TB] FAIL b2b_lo: got %h, expected 00000100", lo); end
    driveOp(OP_DIVU, 32'h100, 32'h10);
    waitIdle(bc, dp);
    readHiLo(hi, lo);
    checks++; if (lo !== 32'h10) begin errors++; $display("[TB] FAIL b2b_div_lo: got %h, expected 00000010", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL b2b_div_hi: got %h, expected 00000000", hi); end
  endtask

  task automatic test_reset_mid_op;
    int bc, dp;
    int busySeen;
    logic [31:0] hi, lo;
    driveOp(OP_MTHI, 32'hDEADBEEF, 32'd0);
    driveOp(OP_MTLO, 32'h0BADF00D, 32'd0);
    driveOp(OP_DIV, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b, expected 0", bus.busy); end
    readHiLo(hi, lo);
    checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL midreset_hi: got %h, expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL midreset_lo: got %h, expected 00000000", lo); end
    @(negedge clk);
    reset = 1'b0;
    dp = 0;
    busySeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) dp++;
      if (bus.busy === 1'b1) busySeen++;
    end
    checks++; if (dp !== 0) begin errors++; $display("[TB] FAIL midreset_no_done: got %0d, expected 0", dp); end
    checks++; if (busySeen !== 0) begin errors++; $display("[TB] FAIL midreset_no_busy: got %0d, expected 0", busySeen); end
    driveOp(OP_MULT, 32'd3, 32'd5);
    waitIdle(bc, dp);
    checks++; if (bc !== 33) begin errors++; $display("[TB] FAIL postreset_busy_cycles: got %0d, expected 33", bc); end
    readHiLo(hi, lo);
    checks++; if (lo !== 32'd15) begin errors++; $display("[TB] FAIL postreset_lo: got %h, expected 0000000f", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL postreset_hi: got %h, expected 00000000", hi); end
  endtask

  // Scenario sequence
  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.rd_hi    = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_mult();
    test_multu();
    test_div();
    test_div_by_zero();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
